q100_exu_csr_ctrl: RTL and testbench
====================================

// Module: q100_exu_csr_ctrl
// PURPOSE
//  Initiator side of the EXU CSR port: executes one Zicsr instruction as a read-modify-write sequence.
//  Drives csr_addr/csr_vld/csr_wdata into the CSR file and samples its combinational read data.
//  Returns the old CSR value to the register-file writeback stage. Sits between decode and the CSR file.
// PARAMETERS
//  DATA_W  32  CSR data width; equals `LEN_CSR
//  ADDR_W  12  CSR address width; equals `LEN_CSR_ADDR
// PORTS
//  clk          in   1       clock
//  rst_n        in   1       synchronous reset, active low
//  req_vld_i    in   1       CSR instruction request valid
//  req_rdy_o    out  1       request accepted when req_vld_i & req_rdy_o
//  req_op_i     in   3       funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
//  req_addr_i   in   ADDR_W  CSR address
//  req_src_i    in   DATA_W  rs1 value (register variants)
//  req_rs1_i    in   5       rs1 index (reg variants) / zimm (imm variants)
//  req_rd_i     in   5       destination register index
//  csr_addr_o   out  ADDR_W  CSR address to CSR file
//  csr_wdata_o  out  DATA_W  CSR write data
//  csr_vld_o    out  1       CSR write strobe, one cycle
//  csr_rdata_i  in   DATA_W  CSR read data, combinational from csr_addr_o
//  wb_vld_o     out  1       writeback valid
//  wb_rdy_i     in   1       writeback ready
//  wb_rd_o      out  5       writeback register index
//  wb_data_o    out  DATA_W  old CSR value
//  illegal_o    out  1       illegal access flag (see CONFIGURATION)
// BEHAVIOUR
//  FSM: IDLE -> RD -> WR -> RESP -> IDLE. req_rdy_o=1 only in IDLE with rst_n high.
//  IDLE: on accept, latch op/addr/rd; operand = req_src_i (reg) or zero-extended req_rs1_i (imm).
//  RD (cycle+1): csr_addr_o=addr; register old=csr_rdata_i. new = RW:op, RS:old|op, RC:old&~op.
//  WR (cycle+2): csr_addr_o=addr, csr_wdata_o=new, csr_vld_o=1 unless suppressed.
//  RESP (cycle+3): wb_vld_o=1, wb_data_o=old, wb_rd_o=rd. Hold all until wb_rdy_i; then IDLE.
//  Throughput: at most one request per 4 cycles; a request is never accepted in RD/WR/RESP.
//  Write suppressed for RS/RC/RSI/RCI when req_rs1_i==0; RW/RWI always write.
//  rd==0: full sequence still runs, wb_vld_o asserted with wb_rd_o=0; regfile discards.
//  Ops 000/100: accepted, no CSR read/write, go to RESP with wb_data_o=0.
//  csr_addr_o/csr_wdata_o/wb_* are 0 outside the states that drive them.
//  Reset values: state IDLE, all outputs 0, latched fields 0.
//  Reset mid-operation: sequence dropped; no csr_vld_o or wb_vld_o issued afterwards.
// CONFIGURATION
//  Macro Q100_CSR_ACCESS_CHECK_EN:
//   defined: in RD, an unsuppressed write to addr[11:10]==2'b11 (read-only space) is illegal;
//    WR then emits no csr_vld_o; RESP asserts illegal_o=1 with wb_vld_o=0 for one cycle, then IDLE.
//    Ops 000/100 are also illegal, handled the same way.
//   undefined: illegal_o tied 0; read-only addresses are written like any other.
// TESTING
//  T1 CSRRW `CSR_DONE_STATUS, src=0x1, old=0 -> csr_vld_o at c+2 with wdata 0x1; wb_data_o=0x0 at c+3; done_intr=1.
//  T2 CSRRS src=0x6 on old 0x1 -> wdata 0x7, wb_data_o 0x1; CSRRCI zimm=1 on 0x7 -> wdata 0x6, wb 0x7.
//  T3 CSRRS/CSRRC with rs1=0 -> no csr_vld_o at c+2; wb_data_o=current value.
//  T4 wb_rdy_i low 3 cycles in RESP -> wb_* stable, req_rdy_o=0; second req_vld_i held is accepted after the handshake.
//  T5 rst_n low during WR -> no csr_vld_o or wb_vld_o; req_rdy_o=1 the cycle after rst_n rises.
//  T6 (macro on) CSRRW addr 0xC00 -> illegal_o=1 at c+3, no csr_vld_o, wb_vld_o=0; macro off -> write issued.

Source files
------------

// File: rtl/q100_exu_csr_ctrl.sv
// q100_exu_csr_ctrl
//   Initiator side of the EXU CSR port. Executes one Zicsr instruction as a
//   read-modify-write sequence IDLE -> RD -> WR -> RESP and returns the old
//   CSR value to register-file writeback.
//   Optional feature macro: Q100_CSR_ACCESS_CHECK_EN
//     defined   : writes to the read-only space (addr[11:10]==2'b11) and the
//                 reserved ops 000/100 are flagged on illegal_o, with no write
//                 and no writeback.
//     undefined : illegal_o is tied low and every address is writable.
module q100_exu_csr_ctrl #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_vld_i,
   output logic              req_rdy_o,
   input  logic [2:0]        req_op_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [DATA_W-1:0] req_src_i,
   input  logic [4:0]        req_rs1_i,
   input  logic [4:0]        req_rd_i,
   output logic [ADDR_W-1:0] csr_addr_o,
   output logic [DATA_W-1:0] csr_wdata_o,
   output logic              csr_vld_o,
   input  logic [DATA_W-1:0] csr_rdata_i,
   output logic              wb_vld_o,
   input  logic              wb_rdy_i,
   output logic [4:0]        wb_rd_o,
   output logic [DATA_W-1:0] wb_data_o,
   output logic              illegal_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   state_t              state_r;
   state_t              state_nxt_s;

   logic [1:0]          kind_r;      // funct3[1:0]: 01 write, 10 set, 11 clear
   logic [ADDR_W-1:0]   addr_r;
   logic [4:0]          rd_r;
   logic [DATA_W-1:0]   operand_r;
   logic [DATA_W-1:0]   old_r;
   logic                suppress_r;  // set/clear with rs1/zimm == 0: no write
   logic                illegal_r;
   logic [DATA_W-1:0]   new_s;
   logic                accept_s;

   // Ops 000/100 carry no read-modify-write kind.
   function automatic logic op_is_rmw(input logic [2:0] op);
      return (op[1:0] != 2'b00);
   endfunction

   // Set/clear with a zero source never write; plain writes always do.
   function automatic logic write_suppressed(input logic [2:0] op, input logic [4:0] rs1);
      return (op[1:0] != 2'b01) && (rs1 == 5'd0);
   endfunction

   // Immediate forms take the 5-bit zimm, zero-extended.
   function automatic logic [DATA_W-1:0] select_operand(input logic [2:0] op,
                                                        input logic [DATA_W-1:0] src,
                                                        input logic [4:0] zimm);
      logic [DATA_W-1:0] res;
      if (op[2]) begin
         res = {{(DATA_W-5){1'b0}}, zimm};
      end else begin
         res = src;
      end
      return res;
   endfunction

   // New CSR value from the old value and the operand.
   function automatic logic [DATA_W-1:0] calc_new(input logic [1:0] kind,
                                                  input logic [DATA_W-1:0] old,
                                                  input logic [DATA_W-1:0] opnd);
      logic [DATA_W-1:0] res;
      case (kind)
         2'b01:   res = opnd;
         2'b10:   res = old | opnd;
         2'b11:   res = old & ~opnd;
         default: res = old;
      endcase
      return res;
   endfunction

   assign accept_s = req_vld_i & req_rdy_o;
   assign new_s    = calc_new(kind_r, old_r, operand_r);

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Request fields latched on accept; old value captured in RD.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         kind_r     <= 2'b00;
         addr_r     <= {ADDR_W{1'b0}};
         rd_r       <= 5'd0;
         operand_r  <= {DATA_W{1'b0}};
         old_r      <= {DATA_W{1'b0}};
         suppress_r <= 1'b0;
         illegal_r  <= 1'b0;
      end else if (accept_s) begin
         kind_r     <= req_op_i[1:0];
         addr_r     <= req_addr_i;
         rd_r       <= req_rd_i;
         operand_r  <= select_operand(req_op_i, req_src_i, req_rs1_i);
         old_r      <= {DATA_W{1'b0}};
         suppress_r <= write_suppressed(req_op_i, req_rs1_i);
`ifdef Q100_CSR_ACCESS_CHECK_EN
         illegal_r  <= !op_is_rmw(req_op_i);
`else
         illegal_r  <= 1'b0;
`endif
      end else if (state_r == ST_RD) begin
         old_r      <= csr_rdata_i;
`ifdef Q100_CSR_ACCESS_CHECK_EN
         illegal_r  <= (addr_r[ADDR_W-1 -: 2] == 2'b11) && !suppress_r;
`else
         illegal_r  <= 1'b0;
`endif
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               if (op_is_rmw(req_op_i)) begin
                  state_nxt_s = ST_RD;
               end else begin
                  state_nxt_s = ST_RESP;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RD:   state_nxt_s = ST_WR;
         ST_WR:   state_nxt_s = ST_RESP;
         ST_RESP: begin
            // An illegal response is a one-cycle flag with no handshake.
            if (illegal_r || wb_rdy_i) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_RESP;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Outputs decoded from state; all forced low while rst_n is low so a
   // sequence interrupted by reset never emits a strobe.
   always_comb begin
      req_rdy_o   = 1'b0;
      csr_addr_o  = {ADDR_W{1'b0}};
      csr_wdata_o = {DATA_W{1'b0}};
      csr_vld_o   = 1'b0;
      wb_vld_o    = 1'b0;
      wb_rd_o     = 5'd0;
      wb_data_o   = {DATA_W{1'b0}};
      illegal_o   = 1'b0;
      if (rst_n) begin
         case (state_r)
            ST_IDLE: req_rdy_o = 1'b1;
            ST_RD:   csr_addr_o = addr_r;
            ST_WR: begin
               csr_addr_o = addr_r;
               if (!suppress_r && !illegal_r) begin
                  csr_wdata_o = new_s;
                  csr_vld_o   = 1'b1;
               end else begin
                  csr_wdata_o = {DATA_W{1'b0}};
                  csr_vld_o   = 1'b0;
               end
            end
            ST_RESP: begin
               if (illegal_r) begin
                  illegal_o = 1'b1;
               end else begin
                  wb_vld_o  = 1'b1;
                  wb_rd_o   = rd_r;
                  wb_data_o = old_r;
               end
            end
            default: req_rdy_o = 1'b0;
         endcase
      end else begin
         req_rdy_o = 1'b0;
      end
   end

endmodule

// File: tb/tb_q100_exu_csr_ctrl.sv
// Testbench for q100_exu_csr_ctrl: a small CSR file model, a table of
// directed vectors, hand-written back-pressure and reset sequences, then
// random requests checked against a reference model.
// Build with +define+Q100_CSR_ACCESS_CHECK_EN to exercise the access check.
module tb_q100_exu_csr_ctrl;

   logic        clk;
   logic        rst_n;
   logic        req_vld_i;
   logic        req_rdy_o;
   logic [2:0]  req_op_i;
   logic [11:0] req_addr_i;
   logic [31:0] req_src_i;
   logic [4:0]  req_rs1_i;
   logic [4:0]  req_rd_i;
   logic [11:0] csr_addr_o;
   logic [31:0] csr_wdata_o;
   logic        csr_vld_o;
   logic [31:0] csr_rdata_i;
   logic        wb_vld_o;
   logic        wb_rdy_i;
   logic [4:0]  wb_rd_o;
   logic [31:0] wb_data_o;
   logic        illegal_o;

   logic        tb_clear;
   logic [31:0] csr_mem [4096];
   logic [31:0] ref_mem [4096];

   int n_pass;
   int n_total;

   q100_exu_csr_ctrl #(.DATA_W(32), .ADDR_W(12)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_vld_i   (req_vld_i),
      .req_rdy_o   (req_rdy_o),
      .req_op_i    (req_op_i),
      .req_addr_i  (req_addr_i),
      .req_src_i   (req_src_i),
      .req_rs1_i   (req_rs1_i),
      .req_rd_i    (req_rd_i),
      .csr_addr_o  (csr_addr_o),
      .csr_wdata_o (csr_wdata_o),
      .csr_vld_o   (csr_vld_o),
      .csr_rdata_i (csr_rdata_i),
      .wb_vld_o    (wb_vld_o),
      .wb_rdy_i    (wb_rdy_i),
      .wb_rd_o     (wb_rd_o),
      .wb_data_o   (wb_data_o),
      .illegal_o   (illegal_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // CSR file: combinational read, write on strobe.
   assign csr_rdata_i = csr_mem[csr_addr_o];
   always @(posedge clk) begin
      if (tb_clear) begin
         for (int i = 0; i < 4096; i++) csr_mem[i] <= 32'd0;
      end else if (csr_vld_o) begin
         csr_mem[csr_addr_o] <= csr_wdata_o;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
   endtask

   // One request through the full handshake with cycle-by-cycle checks.
   task automatic run_req(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] src,
                          input logic [4:0] rs1, input logic [4:0] rd, input int stall,
                          input logic [31:0] exp_wb, input logic exp_wr,
                          input logic [31:0] exp_wd, input logic exp_ill);
      @(negedge clk);
      chk("idle_rdy", {31'd0, req_rdy_o}, 32'd1);
      req_vld_i = 1'b1; req_op_i = op; req_addr_i = addr;
      req_src_i = src;  req_rs1_i = rs1; req_rd_i = rd;
      @(negedge clk);
      req_vld_i = 1'b0;
      if (op[1:0] != 2'b00) begin
         chk("rd_addr", {20'd0, csr_addr_o}, {20'd0, addr});
         chk("rd_vld", {31'd0, csr_vld_o}, 32'd0);
         chk("rd_rdy", {31'd0, req_rdy_o}, 32'd0);
         @(negedge clk);
         chk("wr_vld", {31'd0, csr_vld_o}, {31'd0, exp_wr});
         if (exp_wr) begin
            chk("wr_addr", {20'd0, csr_addr_o}, {20'd0, addr});
            chk("wr_data", csr_wdata_o, exp_wd);
         end
         @(negedge clk);
      end
      chk("resp_ill", {31'd0, illegal_o}, {31'd0, exp_ill});
      if (exp_ill) begin
         chk("ill_wbvld", {31'd0, wb_vld_o}, 32'd0);
         @(negedge clk);
         chk("ill_clr", {31'd0, illegal_o}, 32'd0);
         chk("ill_rdy", {31'd0, req_rdy_o}, 32'd1);
      end else begin
         for (int k = 0; k <= stall; k++) begin
            if (k == stall) wb_rdy_i = 1'b1;
            chk("wb_vld", {31'd0, wb_vld_o}, 32'd1);
            chk("wb_data", wb_data_o, exp_wb);
            chk("wb_rd", {27'd0, wb_rd_o}, {27'd0, rd});
            chk("resp_rdy", {31'd0, req_rdy_o}, 32'd0);
            if (k < stall) @(negedge clk);
         end
         @(negedge clk);
         wb_rdy_i = 1'b0;
         chk("wb_drop", {31'd0, wb_vld_o}, 32'd0);
         chk("post_rdy", {31'd0, req_rdy_o}, 32'd1);
      end
      if (exp_wr) ref_mem[addr] = exp_wd;
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [11:0] addr;
      logic [31:0] src;
      logic [4:0]  rs1;
      logic [4:0]  rd;
      int          stall;
      logic [31:0] wb;
      logic        wr;       // write expected without the access check
      logic [31:0] wd;
      logic        ill_chk;  // illegal when the access check is built in
   } vec_t;

   vec_t vec [13];

   initial begin
      logic        ill, wr, use_wr;
      logic [1:0]  kind;
      logic [31:0] opnd, old, nv, wbv;
      logic [11:0] ra;
      logic [2:0]  rop;
      logic [4:0]  rrs1;
      logic [11:0] addr_pool [5];

      n_pass = 0; n_total = 0;
      for (int i = 0; i < 4096; i++) ref_mem[i] = 32'd0;

      //          op    addr      src            rs1    rd     st wb            wr    wd            ill
      vec[0]  = '{3'd1, 12'h300, 32'h0000_0001, 5'd5,  5'd3,  0, 32'h0,        1'b1, 32'h1,        1'b0};
      vec[1]  = '{3'd2, 12'h300, 32'h0000_0006, 5'd6,  5'd4,  0, 32'h1,        1'b1, 32'h7,        1'b0};
      vec[2]  = '{3'd7, 12'h300, 32'hDEAD_BEEF, 5'd1,  5'd5,  1, 32'h7,        1'b1, 32'h6,        1'b0};
      vec[3]  = '{3'd2, 12'h300, 32'h0000_00FF, 5'd0,  5'd6,  0, 32'h6,        1'b0, 32'h0,        1'b0};
      vec[4]  = '{3'd3, 12'h300, 32'h0000_00FF, 5'd0,  5'd6,  0, 32'h6,        1'b0, 32'h0,        1'b0};
      vec[5]  = '{3'd5, 12'h301, 32'hFFFF_FFFF, 5'd31, 5'd0,  0, 32'h0,        1'b1, 32'h1F,       1'b0};
      vec[6]  = '{3'd0, 12'h301, 32'h0000_1234, 5'd3,  5'd9,  0, 32'h0,        1'b0, 32'h0,        1'b1};
      vec[7]  = '{3'd1, 12'hC00, 32'h0000_ABCD, 5'd2,  5'd10, 0, 32'h0,        1'b1, 32'hABCD,     1'b1};
      vec[8]  = '{3'd6, 12'h301, 32'h0000_0000, 5'd16, 5'd11, 2, 32'h1F,       1'b1, 32'h1F,       1'b0};
      vec[9]  = '{3'd7, 12'hC01, 32'h0000_0000, 5'd0,  5'd12, 0, 32'h0,        1'b0, 32'h0,        1'b0};
      vec[10] = '{3'd4, 12'h301, 32'h0000_0000, 5'd3,  5'd13, 0, 32'h0,        1'b0, 32'h0,        1'b1};
      vec[11] = '{3'd3, 12'h301, 32'h0000_00F0, 5'd7,  5'd14, 0, 32'h1F,       1'b1, 32'h0F,       1'b0};
      vec[12] = '{3'd1, 12'h301, 32'h0000_0000, 5'd0,  5'd1,  0, 32'h0F,       1'b1, 32'h0,        1'b0};

      // Reset state.
      rst_n = 1'b0; tb_clear = 1'b1; req_vld_i = 1'b0; wb_rdy_i = 1'b0;
      req_op_i = 3'd0; req_addr_i = 12'd0; req_src_i = 32'd0; req_rs1_i = 5'd0; req_rd_i = 5'd0;
      repeat (3) @(negedge clk);
      chk("rst_rdy", {31'd0, req_rdy_o}, 32'd0);
      chk("rst_csr_vld", {31'd0, csr_vld_o}, 32'd0);
      chk("rst_wb_vld", {31'd0, wb_vld_o}, 32'd0);
      chk("rst_ill", {31'd0, illegal_o}, 32'd0);
      chk("rst_addr", {20'd0, csr_addr_o}, 32'd0);
      chk("rst_wdata", csr_wdata_o, 32'd0);
      chk("rst_wb", {wb_data_o[26:0], wb_rd_o}, 32'd0);
      tb_clear = 1'b0; rst_n = 1'b1;

      // Directed table.
      for (int i = 0; i < 13; i++) begin
         ill = 1'b0;
`ifdef Q100_CSR_ACCESS_CHECK_EN
         ill = vec[i].ill_chk;
`endif
         wr = vec[i].wr && !ill;
         run_req(vec[i].op, vec[i].addr, vec[i].src, vec[i].rs1, vec[i].rd, vec[i].stall,
                 vec[i].wb, wr, vec[i].wd, ill);
      end

      // Reset during WR: the write and the writeback are dropped.
      @(negedge clk);
      req_vld_i = 1'b1; req_op_i = 3'd1; req_addr_i = 12'h302; req_src_i = 32'h55;
      req_rs1_i = 5'd1; req_rd_i = 5'd2;
      @(negedge clk);
      req_vld_i = 1'b0;
      chk("t5_rd_addr", {20'd0, csr_addr_o}, 32'h302);
      @(posedge clk);
      #1 rst_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t5_csr_vld", {31'd0, csr_vld_o}, 32'd0);
         chk("t5_wb_vld", {31'd0, wb_vld_o}, 32'd0);
      end
      chk("t5_rdy_low", {31'd0, req_rdy_o}, 32'd0);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t5_rdy", {31'd0, req_rdy_o}, 32'd1);
         chk("t5_no_strobe", {30'd0, csr_vld_o, wb_vld_o}, 32'd0);
      end
      chk("t5_mem", csr_mem[12'h302], 32'd0);

      // Back-pressure with a second request held pending.
      @(negedge clk);
      req_vld_i = 1'b1; req_op_i = 3'd1; req_addr_i = 12'h303; req_src_i = 32'h11;
      req_rs1_i = 5'd1; req_rd_i = 5'd7;
      @(negedge clk);
      req_op_i = 3'd2; req_src_i = 32'h22; req_rs1_i = 5'd2; req_rd_i = 5'd8;
      chk("t4_rd_rdy", {31'd0, req_rdy_o}, 32'd0);
      @(negedge clk);
      chk("t4_wr_data", csr_wdata_o, 32'h11);
      chk("t4_wr_rdy", {31'd0, req_rdy_o}, 32'd0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (k == 3) wb_rdy_i = 1'b1;
         chk("t4_wb_vld", {31'd0, wb_vld_o}, 32'd1);
         chk("t4_wb_data", wb_data_o, 32'h0);
         chk("t4_wb_rd", {27'd0, wb_rd_o}, 32'd7);
         chk("t4_resp_rdy", {31'd0, req_rdy_o}, 32'd0);
      end
      @(negedge clk);
      wb_rdy_i = 1'b0;
      chk("t4_idle_rdy", {31'd0, req_rdy_o}, 32'd1);
      chk("t4_wb_drop", {31'd0, wb_vld_o}, 32'd0);
      @(negedge clk);
      req_vld_i = 1'b0;
      chk("t4_2nd_addr", {20'd0, csr_addr_o}, 32'h303);
      @(negedge clk);
      chk("t4_2nd_vld", {31'd0, csr_vld_o}, 32'd1);
      chk("t4_2nd_data", csr_wdata_o, 32'h33);
      @(negedge clk);
      wb_rdy_i = 1'b1;
      chk("t4_2nd_wb", wb_data_o, 32'h11);
      chk("t4_2nd_rd", {27'd0, wb_rd_o}, 32'd8);
      @(negedge clk);
      wb_rdy_i = 1'b0;
      chk("t4_2nd_done", {31'd0, wb_vld_o}, 32'd0);
      ref_mem[12'h303] = 32'h33;

      // Random requests against the reference model.
      addr_pool[0] = 12'h300; addr_pool[1] = 12'h301; addr_pool[2] = 12'h340;
      addr_pool[3] = 12'hC00; addr_pool[4] = 12'hC01;
      for (int i = 0; i < 60; i++) begin
         rop  = 3'($urandom_range(0, 7));
         ra   = addr_pool[$urandom_range(0, 4)];
         rrs1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         kind = rop[1:0];
         opnd = rop[2] ? {27'd0, rrs1} : 32'h0;
         if (!rop[2]) opnd = $urandom;
         old  = ref_mem[ra];
         case (kind)
            2'b01:   nv = opnd;
            2'b10:   nv = old | opnd;
            2'b11:   nv = old & ~opnd;
            default: nv = 32'd0;
         endcase
         use_wr = (kind == 2'b01) || (kind != 2'b00 && rrs1 != 5'd0);
         wbv    = (kind != 2'b00) ? old : 32'd0;
         ill    = 1'b0;
`ifdef Q100_CSR_ACCESS_CHECK_EN
         ill = (kind == 2'b00) || (use_wr && ra[11:10] == 2'b11);
`endif
         if (ill) use_wr = 1'b0;
         run_req(rop, ra, opnd, rrs1, 5'($urandom_range(0, 31)), int'($urandom_range(0, 2)),
                 wbv, use_wr, nv, ill);
      end

      for (int j = 0; j < 5; j++) begin
         chk("mem_final", csr_mem[addr_pool[j]], ref_mem[addr_pool[j]]);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
